// File: rtl/credential_matcher.sv
// credential_matcher: scans the ID/password ROM word stream and reports a match after the full table.
// Optional lockout after MAX_FAILS consecutive failed checks: define CREDENTIAL_LOCKOUT_EN.
module credential_matcher #(
  parameter int NUM_RECORDS = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_FAILS   = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Check,
  input  logic [31:0] UserId,
  input  logic [31:0] UserPw,
  input  logic [31:0] WordIn,
  input  logic        WordValid,
  output logic        StartOut,
  output logic        Busy,
  output logic        Done,
  output logic        Match,
  output logic        TimeoutErr,
  output logic        Locked
);
  localparam int RW = $clog2(NUM_RECORDS + 1);
  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_ID, S_WAIT_PW, S_DONE} state_t;

  state_t        state_reg;
  logic [31:0]   id_reg;
  logic [31:0]   pw_reg;
  logic          id_hit_reg;
  logic          found_reg;
  logic          start_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          match_reg;
  logic          timeout_reg;
  logic [RW-1:0] rec_reg;
  logic [SW-1:0] stall_reg;
  logic          locked_w;
  logic          pw_hit;
  logic          stall_expired;

  assign pw_hit        = id_hit_reg && (WordIn == pw_reg);
  assign stall_expired = (stall_reg == SW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= S_IDLE;
      id_reg      <= '0;
      pw_reg      <= '0;
      id_hit_reg  <= 1'b0;
      found_reg   <= 1'b0;
      start_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      match_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      rec_reg     <= '0;
      stall_reg   <= '0;
    end else begin
      start_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (Check && !locked_w) begin
            id_reg      <= UserId;
            pw_reg      <= UserPw;
            match_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            found_reg   <= 1'b0;
            rec_reg     <= '0;
            start_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= S_REQ;
          end
        end
        S_REQ: begin
          stall_reg <= '0;
          state_reg <= S_WAIT_ID;
        end
        S_WAIT_ID, S_WAIT_PW: begin
          if (WordValid) begin
            stall_reg <= '0;
            if (state_reg == S_WAIT_ID) begin
              id_hit_reg <= (WordIn == id_reg);
              state_reg  <= S_WAIT_PW;
            end else begin
              rec_reg <= rec_reg + 1'b1;
              if (rec_reg == RW'(NUM_RECORDS - 1)) begin
                // Result is committed on the way into DONE so it is valid in the Done cycle.
                match_reg <= found_reg | pw_hit;
                done_reg  <= 1'b1;
                state_reg <= S_DONE;
              end else begin
                found_reg <= found_reg | pw_hit;
                state_reg <= S_WAIT_ID;
              end
            end
          end else if (stall_expired) begin
            timeout_reg <= 1'b1;
            match_reg   <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= S_DONE;
          end else begin
            stall_reg <= stall_reg + 1'b1;
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef CREDENTIAL_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0] fails_reg;
  logic          locked_reg;

  // Timeouts leave the fail count untouched; only real mismatches count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fails_reg  <= '0;
      locked_reg <= 1'b0;
    end else if (done_reg && !timeout_reg) begin
      if (match_reg) begin
        fails_reg <= '0;
      end else if (!locked_reg) begin
        fails_reg <= fails_reg + 1'b1;
        if (fails_reg == FW'(MAX_FAILS - 1))
          locked_reg <= 1'b1;
      end
    end
  end

  assign locked_w = locked_reg;
`else
  localparam int unused_max_fails = MAX_FAILS;
  assign locked_w = 1'b0;
`endif

  assign StartOut   = start_reg;
  assign Busy       = busy_reg;
  assign Done       = done_reg;
  assign Match      = match_reg;
  assign TimeoutErr = timeout_reg;
  assign Locked     = locked_w;
endmodule
